// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle CPU memory port.
// Byte-addressed RAM behind an IDLE -> WAIT -> ACCESS handshake with a
// programmable number of wait states. Read data and ready_o are registered;
// ready_o pulses for exactly one cycle when an access completes.
// Optional build macro: MEM_ALIGN_CHECK_EN enables the misaligned word-read
// check (sets err_o, returns zero data, skips the RAM read).
module mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic              size_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    output logic [31:0]       rdata_o,
    output logic              ready_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_e;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic [AW-1:0]   addr_q;
    logic            size_q;
    logic            write_q;
    logic            bad_q;
    logic [7:0]      wdata_q;
    logic [31:0]     rdata_q;
    logic            ready_q;
    logic            busy_q;
    logic            err_q;
    logic [7:0]      ram_q [DEPTH];

    // Request decode and the operands of the access about to happen.
    logic            req;
    logic            in_bad;
    logic            go_access;
    logic            eff_write;
    logic            eff_size;
    logic            eff_bad;
    logic [AW-1:0]   eff_addr;
    logic [7:0]      eff_wdata;
    logic [31:0]     rd_data;

    // Address bits above the RAM index only select aliases of the same bytes.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^addr_i[ADDR_W-1:AW];

    // Decode the request and pick live inputs (zero-wait accept) or latched copy.
    always_comb begin
        req    = memread_i | memwrite_i;
        in_bad = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        in_bad = memread_i & ~memwrite_i & size_i & (addr_i[1:0] != 2'b00);
`endif
        if (state_q == S_IDLE) begin
            eff_write = memwrite_i;
            eff_size  = size_i;
            eff_bad   = in_bad;
            eff_addr  = addr_i[AW-1:0];
            eff_wdata = wdata_i;
        end else begin
            eff_write = write_q;
            eff_size  = size_q;
            eff_bad   = bad_q;
            eff_addr  = addr_q;
            eff_wdata = wdata_q;
        end

        go_access = 1'b0;
        if (state_q == S_IDLE && req && WAIT_CYCLES == 0) begin
            go_access = 1'b1;
        end else if (state_q == S_WAIT && req && cnt_q == 4'd1) begin
            go_access = 1'b1;
        end

        // Byte indices wrap naturally in AW bits.
        if (eff_bad) begin
            rd_data = 32'h0000_0000;
        end else if (eff_size) begin
            rd_data = {ram_q[eff_addr + AW'(3)], ram_q[eff_addr + AW'(2)],
                       ram_q[eff_addr + AW'(1)], ram_q[eff_addr]};
        end else begin
            rd_data = {24'h0, ram_q[eff_addr]};
        end
    end

    // RAM write port; a write lands on the edge entering ACCESS.
    // NOTE: the RAM array has no reset branch so it maps onto plain storage;
    // rst_n only gates the write so a request held during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && go_access && eff_write) begin
            ram_q[eff_addr] <= eff_wdata;
        end
    end

    // Handshake FSM with registered ready/busy/err/rdata outputs.
    // NOTE: every state register uses non-blocking assignment so all of them
    // see pre-edge values of each other regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            size_q  <= 1'b0;
            write_q <= 1'b0;
            bad_q   <= 1'b0;
            wdata_q <= 8'h00;
            rdata_q <= 32'h0000_0000;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (go_access && !eff_write) begin
                rdata_q <= rd_data;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (req) begin
                        addr_q  <= addr_i[AW-1:0];
                        size_q  <= size_i;
                        write_q <= memwrite_i;
                        bad_q   <= in_bad;
                        wdata_q <= wdata_i;
                        cnt_q   <= WAIT_LD;
                        busy_q  <= 1'b1;
                        err_q   <= err_q | (memread_i & memwrite_i) | in_bad;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= S_ACCESS;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= S_ACCESS;
                        cnt_q   <= 4'd0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ACCESS: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rdata_o = rdata_q;
    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a transaction-level model predicts
// ready/busy/err/rdata each cycle; a compare process checks them on the
// falling edge, and directed vectors pin the model with literal values.
module tb_mem_responder;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 256;
    localparam int W      = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              memread;
    logic              memwrite;
    logic              size;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic [31:0]       rdata;
    logic              ready;
    logic              busy;
    logic              err;

    mem_responder #(
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .memread_i  (memread),
        .memwrite_i (memwrite),
        .size_i     (size),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .ready_o    (ready),
        .busy_o     (busy),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Model state.
    logic [7:0]  mem_m [DEPTH];
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_ready = 1'b0;
    logic        exp_busy  = 1'b0;
    logic        exp_err   = 1'b0;
    logic        cmp_en    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic sz, input logic [31:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (!sz) return {24'h0, mem_m[a[7:0]]};
`ifdef MEM_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) return 32'h0;
`endif
        for (int i = 0; i < 4; i++) begin
            logic [31:0] s;
            s = a + 32'(i);
            r = r | (32'(mem_m[s[7:0]]) << (8 * i));
        end
        return r;
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("ready_o", 32'(ready), 32'(exp_ready));
            check("busy_o",  32'(busy),  32'(exp_busy));
            check("err_o",   32'(err),   32'(exp_err));
            check("rdata_o", rdata,      exp_rdata);
        end
    end

    // One requester transaction; drop_at >= 0 drops the strobes in that WAIT cycle.
    task automatic txn(input logic rd, input logic wr, input logic sz,
                       input logic [31:0] a, input logic [7:0] wd, input int drop_at);
        @(posedge clk); #1;
        memread = rd; memwrite = wr; size = sz; addr = a; wdata = wd;
        exp_ready = 1'b0; exp_busy = 1'b0;
        @(posedge clk); #1;   // accept edge passed
        exp_busy = 1'b1;
        exp_err  = exp_err | (rd & wr);
`ifdef MEM_ALIGN_CHECK_EN
        exp_err  = exp_err | (rd & ~wr & sz & (a[1:0] != 2'b00));
`endif
        // Inputs other than strobes are ignored once accepted.
        addr = ~a; wdata = ~wd; size = ~sz;
        for (int i = 0; i < W; i++) begin
            if (i == drop_at) begin
                memread = 1'b0; memwrite = 1'b0;
                @(posedge clk); #1;
                exp_busy = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        // ACCESS cycle.
        exp_ready = 1'b1;
        if (wr) mem_m[a[7:0]] = wd;
        else    exp_rdata = model_read(sz, a);
        @(posedge clk); #1;
        memread = 1'b0; memwrite = 1'b0;
        exp_ready = 1'b0; exp_busy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; memread = 1'b0; memwrite = 1'b0; size = 1'b0;
        addr = '0; wdata = 8'h00;
        #12;
        check("reset rdata_o", rdata, 32'h0);
        check("reset ready_o", 32'(ready), 32'h0);
        check("reset busy_o",  32'(busy),  32'h0);
        check("reset err_o",   32'(err),   32'h0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // 1: SB 0x10=0xA5 then LB 0x10.
        txn(1'b0, 1'b1, 1'b0, 32'h10, 8'hA5, -1);
        txn(1'b1, 1'b0, 1'b0, 32'h10, 8'h00, -1);
        check("lb 0x10", rdata, 32'h0000_00A5);

        // 2: four byte stores and a word read.
        txn(1'b0, 1'b1, 1'b0, 32'h20, 8'h11, -1);
        txn(1'b0, 1'b1, 1'b0, 32'h21, 8'h22, -1);
        txn(1'b0, 1'b1, 1'b0, 32'h22, 8'h33, -1);
        txn(1'b0, 1'b1, 1'b0, 32'h23, 8'h44, -1);
        txn(1'b1, 1'b0, 1'b1, 32'h20, 8'h00, -1);
        check("lw 0x20", rdata, 32'h4433_2211);

        // 3: address wrap.
        txn(1'b0, 1'b1, 1'b0, 32'h1FF, 8'h5C, -1);
        txn(1'b1, 1'b0, 1'b0, 32'hFF, 8'h00, -1);
        check("lb wrap 0xff", rdata, 32'h0000_005C);

        // Word read wrapping across the top of the RAM.
        txn(1'b0, 1'b1, 1'b0, 32'hFE, 8'hE1, -1);
        txn(1'b0, 1'b1, 1'b0, 32'h00, 8'h0A, -1);
        txn(1'b0, 1'b1, 1'b0, 32'h01, 8'h0B, -1);
        txn(1'b1, 1'b0, 1'b1, 32'hFE, 8'h00, -1);
        check("lw wrap 0xfe", rdata, 32'h0B0A_5CE1);

        // 4: read dropped after one WAIT cycle; rdata unchanged.
        txn(1'b1, 1'b0, 1'b0, 32'h20, 8'h00, 1);
        @(posedge clk); #1;
        check("abort rdata", rdata, 32'h0B0A_5CE1);
        check("abort busy",  32'(busy), 32'h0);
        // Dropped write has no RAM effect.
        txn(1'b0, 1'b1, 1'b0, 32'h10, 8'hEE, 0);
        txn(1'b1, 1'b0, 1'b0, 32'h10, 8'h00, -1);
        check("abort write no effect", rdata, 32'h0000_00A5);

        // 5: reset in the middle of SB 0x30=0x77.
        txn(1'b0, 1'b1, 1'b0, 32'h30, 8'h66, -1);
        @(posedge clk); #1;
        memwrite = 1'b1; addr = 32'h30; wdata = 8'h77; size = 1'b0;
        @(posedge clk); #1;
        exp_busy = 1'b1;
        #2;
        rst_n = 1'b0;
        exp_busy = 1'b0; exp_ready = 1'b0; exp_rdata = 32'h0; exp_err = 1'b0;
        #1;
        check("midreset busy",  32'(busy),  32'h0);
        check("midreset rdata", rdata,      32'h0);
        memwrite = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        txn(1'b1, 1'b0, 1'b0, 32'h30, 8'h00, -1);
        check("lb 0x30 old", rdata, 32'h0000_0066);

        // Misaligned word read at 0x21 (bytes 0x21..0x24).
        txn(1'b0, 1'b1, 1'b0, 32'h24, 8'h55, -1);
        txn(1'b1, 1'b0, 1'b1, 32'h21, 8'h00, -1);
`ifdef MEM_ALIGN_CHECK_EN
        check("lw 0x21 aligned-check", rdata, 32'h0000_0000);
        check("err misaligned", 32'(err), 32'h1);
`else
        check("lw 0x21 misaligned", rdata, 32'h5544_3322);
        check("err clear", 32'(err), 32'h0);
`endif

        // 6: simultaneous read+write -> write, sticky error.
        txn(1'b1, 1'b1, 1'b1, 32'h40, 8'h9D, -1);
        check("err both", 32'(err), 32'h1);
        txn(1'b1, 1'b0, 1'b0, 32'h40, 8'h00, -1);
        check("lb 0x40", rdata, 32'h0000_009D);
        check("err sticky", 32'(err), 32'h1);

        repeat (2) @(posedge clk);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
